load_store_unit: RTL and testbench

- Memory stage downstream of the execution block. Accepts one load or store per handshake, computes the effective address, and drives the processor's data-memory port (dmem_req/we/addr/wdata, rdata/ack).
- Returns load data to the register-file write port as a one-cycle writeback pulse.
- Asserts busy_o so the fetch/PC logic stalls while an access is outstanding.
- Flags misaligned accesses and accesses that time out.

---
 rtl/simple_processor_pkg.sv | 5 +
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared processor width constants
package simple_processor_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: effective address, dmem handshake, load writeback, error flags
module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      is_store_i,
    input  logic [MEM_DATA_WIDTH-1:0] base_i,
    input  logic [5:0]                offset_i,
    input  logic [MEM_DATA_WIDTH-1:0] store_data_i,
    input  logic [2:0]                rd_addr_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      wb_valid_o,
    output logic [2:0]                wb_rd_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] wb_data_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic                      we_q;
    logic [MEM_DATA_WIDTH-1:0] wdata_q;
    logic [2:0]                rd_q;
    logic                      wb_valid_q;
    logic [2:0]                wb_rd_q;
    logic [MEM_DATA_WIDTH-1:0] wb_data_q;
    logic                      err_q;
    logic [1:0]                err_code_q;

    logic [MEM_ADDR_WIDTH-1:0] ea;
    logic                      accept;
    logic                      timeout_hit;

    // Address arithmetic wraps modulo 2^MEM_ADDR_WIDTH by construction.
    assign ea     = base_i[MEM_ADDR_WIDTH-1:0]
                  + {{(MEM_ADDR_WIDTH-6){offset_i[5]}}, offset_i};
    assign accept = req_valid_i && (state_q == IDLE);

    // cnt_q counts completed ACCESS cycles; hitting TIMEOUT-1 means this is the last one.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT_CYCLES != 0)
            timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !ea[0]) state_d = ACCESS;
            ACCESS:  if (dmem_ack_i || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (ea[0]) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end else begin
                            addr_q  <= ea;
                            we_q    <= is_store_i;
                            wdata_q <= is_store_i ? store_data_i : '0;
                            rd_q    <= rd_addr_i;
                            cnt_q   <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // Ack beats a timeout landing on the same edge.
                    if (dmem_ack_i) begin
                        we_q <= 1'b0;
                        if (!we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= dmem_rdata_i;
                            wb_rd_q    <= rd_q;
                        end
                    end else if (timeout_hit) begin
                        we_q       <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == ACCESS);
    assign dmem_req_o   = (state_q == ACCESS);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        is_store_i;
    logic [15:0] base_i;
    logic [5:0]  offset_i;
    logic [15:0] store_data_i;
    logic [2:0]  rd_addr_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic [15:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        wb_valid_o;
    logic [2:0]  wb_rd_addr_o;
    logic [15:0] wb_data_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int n_pass  = 0;
    int n_total = 0;

    load_store_unit #(
        .MEM_ADDR_WIDTH(16),
        .MEM_DATA_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .is_store_i(is_store_i), .base_i(base_i), .offset_i(offset_i),
        .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic [5:0]  off;
        logic [15:0] sdata;
        logic [2:0]  rd;
        int          delay;
        logic [15:0] rdata;
        logic [15:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive_op(input logic st, input logic [15:0] base, input logic [5:0] off,
                            input logic [15:0] sdata, input logic [2:0] rd);
        req_valid_i  = 1'b1;
        is_store_i   = st;
        base_i       = base;
        offset_i     = off;
        store_data_i = sdata;
        rd_addr_i    = rd;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("ready_before", req_ready_o, 1);
        drive_op(v.st, v.base, v.off, v.sdata, v.rd);
        @(negedge clk);
        req_valid_i = 1'b0;
        if (v.exp_mis) begin
            chk("mis_req", dmem_req_o, 0);
            chk("mis_err", err_o, 1);
            chk("mis_code", err_code_o, 2'b01);
            chk("mis_wb", wb_valid_o, 0);
            @(negedge clk);
            chk("mis_err_pulse", err_o, 0);
            chk("mis_code_held", err_code_o, 2'b01);
        end else begin
            for (int i = 0; i <= v.delay; i++) begin
                chk("acc_req", dmem_req_o, 1);
                chk("acc_busy", busy_o, 1);
                chk("acc_addr", dmem_addr_o, v.exp_addr);
                chk("acc_we", dmem_we_o, v.st);
                chk("acc_wdata", dmem_wdata_o, v.st ? v.sdata : 16'h0);
                if (i == v.delay) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = v.rdata;
                end
                @(negedge clk);
            end
            dmem_ack_i = 1'b0;
            chk("done_req", dmem_req_o, 0);
            chk("done_we", dmem_we_o, 0);
            chk("done_busy", busy_o, 0);
            chk("done_err", err_o, 0);
            chk("wb_valid", wb_valid_o, !v.st);
            if (!v.st) begin
                chk("wb_data", wb_data_o, v.rdata);
                chk("wb_rd", wb_rd_addr_o, v.rd);
                @(negedge clk);
                chk("wb_pulse_end", wb_valid_o, 0);
                chk("wb_data_held", wb_data_o, v.rdata);
            end
        end
    endtask

    initial begin
        int req_cycles;
        vecs[0] = '{1'b0, 16'h0100, 6'h04, 16'h0000, 3'd3, 2, 16'hBEEF, 16'h0104, 1'b0};
        vecs[1] = '{1'b1, 16'h0010, 6'h3E, 16'h1234, 3'd0, 0, 16'h0000, 16'h000E, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFE, 6'h04, 16'h0000, 3'd5, 0, 16'h0A0A, 16'h0002, 1'b0};
        vecs[3] = '{1'b0, 16'h0003, 6'h00, 16'h0000, 3'd1, 0, 16'h0000, 16'h0003, 1'b1};
        vecs[4] = '{1'b1, 16'h2000, 6'h20, 16'hCAFE, 3'd0, 1, 16'h0000, 16'h1FE0, 1'b0};
        vecs[5] = '{1'b0, 16'h0005, 6'h3F, 16'h0000, 3'd7, 1, 16'h5A5A, 16'h0004, 1'b0};

        rst_i = 1'b1; req_valid_i = 1'b0; is_store_i = 1'b0; base_i = '0; offset_i = '0;
        store_data_i = '0; rd_addr_i = '0; dmem_rdata_i = '0; dmem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_wb_rd", wb_rd_addr_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_err_code", err_code_o, 0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Timeout: no ack, request must stay up for exactly 16 cycles.
        @(negedge clk);
        drive_op(1'b0, 16'h0040, 6'h00, 16'h0, 3'd2);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40 && dmem_req_o; i++) begin
            req_cycles++;
            @(negedge clk);
        end
        chk("to_req_cycles", req_cycles, 16);
        chk("to_err", err_o, 1);
        chk("to_code", err_code_o, 2'b10);
        chk("to_ready", req_ready_o, 1);
        chk("to_wb", wb_valid_o, 0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h7777;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("stray_wb", wb_valid_o, 0);
        chk("stray_err", err_o, 0);
        chk("stray_code_held", err_code_o, 2'b10);

        // Reset in the second ACCESS cycle, ack arriving right after.
        @(negedge clk);
        drive_op(1'b1, 16'h0200, 6'h02, 16'hABCD, 3'd6);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("mr_req_up", dmem_req_o, 1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h9999;
        chk("mr_req", dmem_req_o, 0);
        chk("mr_we", dmem_we_o, 0);
        chk("mr_addr", dmem_addr_o, 0);
        chk("mr_wdata", dmem_wdata_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_code", err_code_o, 0);
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("mr_wb", wb_valid_o, 0);
        chk("mr_err", err_o, 0);
        chk("mr_ready", req_ready_o, 1);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        drive_op(1'b0, 16'h0300, 6'h00, 16'h0, 3'd1);
        @(negedge clk);
        drive_op(1'b0, 16'h0400, 6'h06, 16'h0, 3'd4);
        chk("b2b_first_addr", dmem_addr_o, 16'h0300);
        chk("b2b_not_ready", req_ready_o, 0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h1111;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("b2b_wb1", wb_valid_o, 1);
        chk("b2b_wb1_data", wb_data_o, 16'h1111);
        chk("b2b_ready", req_ready_o, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("b2b_second_req", dmem_req_o, 1);
        chk("b2b_second_addr", dmem_addr_o, 16'h0406);
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h2222;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("b2b_wb2_data", wb_data_o, 16'h2222);
        chk("b2b_wb2_rd", wb_rd_addr_o, 3'd4);
        @(negedge clk);
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'hFFFF;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("idle_ack_wb", wb_valid_o, 0);
        chk("idle_ack_data", wb_data_o, 16'h2222);
        chk("idle_ack_req", dmem_req_o, 0);
        chk("idle_ack_busy", busy_o, 0);
        chk("idle_ack_err", err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
